// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type and the 64 round constants K[0..63],
// used by the round-constant ROM, message schedule and compression blocks.
package sha256_pkg;

    localparam int SHA256_ROUNDS = 64;
    localparam int WORD_WIDTH    = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    // First 32 bits of the fractional parts of the cube roots of the first 64 primes.
    localparam word_t K [0:SHA256_ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/round_constant.sv
// Registered SHA-256 round-constant ROM: K[add] appears one clock after an enabled edge.
// Optional macro ROUND_CONSTANT_VALID_EN adds o_valid, registered alongside the constant.
module round_constant
    import sha256_pkg::*;
#(
    parameter int ADDR_WTH = 6,
    parameter int WRD_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [ADDR_WTH-1:0] add,
`ifdef ROUND_CONSTANT_VALID_EN
    output logic                o_valid,
`endif
    output logic [WRD_SIZE-1:0] o_round_constant
);

    if (WRD_SIZE != WORD_WIDTH) begin : g_bad_wrd_size
        $error("round_constant: WRD_SIZE must be 32");
    end
    if (ADDR_WTH < 6) begin : g_bad_addr_wth
        $error("round_constant: ADDR_WTH must be at least 6");
    end

    logic  in_range;
    word_t k_word;

    // Addresses beyond the 64-entry table decode to zero.
    if (ADDR_WTH > 6) begin : g_wide_addr
        assign in_range = (add[ADDR_WTH-1:6] == '0);
    end else begin : g_narrow_addr
        assign in_range = 1'b1;
    end

    always_comb begin
        k_word = '0;
        if (in_range) begin
            k_word = K[add[5:0]];
        end
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            o_round_constant <= '0;
        end else if (enable) begin
            o_round_constant <= k_word;
        end
    end

`ifdef ROUND_CONSTANT_VALID_EN
    always_ff @(posedge clk) begin
        if (reset_n) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= enable;
        end
    end
`endif

endmodule

// File: tb/tb_round_constant.sv
// Self-checking bench for round_constant (ADDR_WTH=7) against an independent
// reference table and a one-register behavioural model.
module tb_round_constant;

    localparam int AW = 7;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [AW-1:0] add;
    logic [31:0]   o_round_constant;
    logic          o_valid_obs;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] exp_rc;
    logic        exp_valid;

    round_constant #(.ADDR_WTH(AW), .WRD_SIZE(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .add              (add),
`ifdef ROUND_CONSTANT_VALID_EN
        .o_valid          (o_valid_obs),
`endif
        .o_round_constant (o_round_constant)
    );

`ifndef ROUND_CONSTANT_VALID_EN
    assign o_valid_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] k_of(input int a);
        if (a < 64) return ref_k[a];
        return 32'h0;
    endfunction

    // Apply inputs, advance one edge, update the model, then compare.
    task automatic step(input logic rst, input logic en, input int a, input string tag);
        reset_n = rst;
        enable  = en;
        add     = AW'(a);
        @(posedge clk);
        if (rst) begin
            exp_rc    = 32'h0;
            exp_valid = 1'b0;
        end else begin
            if (en) exp_rc = k_of(a);
            exp_valid = en;
        end
        #1;
        checks++;
        assert (o_round_constant === exp_rc) else begin
            failures++;
            $error("FAIL %s add=%0d observed=%h expected=%h", tag, a, o_round_constant, exp_rc);
        end
`ifdef ROUND_CONSTANT_VALID_EN
        checks++;
        assert (o_valid_obs === exp_valid) else begin
            failures++;
            $error("FAIL %s_valid observed=%b expected=%b", tag, o_valid_obs, exp_valid);
        end
`endif
    endtask

    // Spot check against literal constants, independent of the model table.
    task automatic spot(input logic [31:0] want, input string tag);
        checks++;
        assert (o_round_constant === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o_round_constant, want);
        end
    endtask

    initial begin
        exp_rc    = 32'h0;
        exp_valid = 1'b0;
        reset_n   = 1'b1;
        enable    = 1'b1;
        add       = AW'(5);

        step(1'b1, 1'b1, 5, "reset_en");
        step(1'b1, 1'b1, 5, "reset_en2");
        spot(32'h0, "reset_zero");

        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, i, "sweep");
            if (i == 0)  spot(32'h428a2f98, "spot_k0");
            if (i == 1)  spot(32'h71374491, "spot_k1");
            if (i == 8)  spot(32'hd807aa98, "spot_k8");
            if (i == 16) spot(32'he49b69c1, "spot_k16");
            if (i == 32) spot(32'h27b70a85, "spot_k32");
            if (i == 63) spot(32'hc67178f2, "spot_k63");
        end

        step(1'b0, 1'b1, 63, "load63");
        step(1'b0, 1'b0, 0, "hold0");
        spot(32'hc67178f2, "hold_k63");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, int'($urandom_range(0, 127)), "hold_rand");

        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, i, "sweep2");
        step(1'b1, 1'b1, 20, "mid_reset");
        spot(32'h0, "mid_reset_zero");
        step(1'b0, 1'b1, 21, "after_reset");
        spot(32'h4a7484aa, "spot_k21");

        step(1'b0, 1'b1, 7, "toggle_1");
        step(1'b0, 1'b0, 9, "toggle_0");
        step(1'b0, 1'b1, 10, "toggle_1b");

        step(1'b0, 1'b1, 64, "oob_64");
        spot(32'h0, "oob_zero");
        step(1'b0, 1'b1, 62, "in_62");
        step(1'b0, 1'b1, 127, "oob_127");
        step(1'b0, 1'b1, 100, "oob_100");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), int'($urandom_range(0, 127)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
